// File: rtl/cell_ram_arbiter_if.sv
// Requester-side bundle of the cell RAM arbiter: the render read port and the
// game req/ack port. The arbiter takes the slave side, requesters the master side.
interface cell_ram_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              render_req;
    logic [ADDR_W-1:0] render_addr;
    logic              render_rvalid;
    logic [DATA_W-1:0] render_rdata;
    logic              game_req;
    logic              game_we;
    logic [ADDR_W-1:0] game_addr;
    logic [DATA_W-1:0] game_wdata;
    logic              game_ack;
    logic              game_rvalid;
    logic [DATA_W-1:0] game_rdata;
    logic              game_starve;

    modport master (
        output render_req, render_addr,
        output game_req, game_we, game_addr, game_wdata,
        input  render_rvalid, render_rdata,
        input  game_ack, game_rvalid, game_rdata, game_starve
    );

    modport slave (
        input  render_req, render_addr,
        input  game_req, game_we, game_addr, game_wdata,
        output render_rvalid, render_rdata,
        output game_ack, game_rvalid, game_rdata, game_starve
    );
endinterface

// File: rtl/cell_ram_arbiter.sv
// Single-port cell-state RAM shared between the pixel renderer (absolute priority,
// fixed latency) and the game logic (req/ack, writes optionally held to vblank).
module cell_ram_arbiter #(
    parameter int VGA_WIDTH       = 12,
    parameter int VSIZE           = 480,
    parameter int ADDR_W          = 9,
    parameter int DATA_W          = 16,
    parameter int RAM_LAT         = 1,
    parameter bit WRITE_IN_VBLANK = 1'b1,
    parameter int STARVE_LIMIT    = 1024
) (
    input  logic                 clk_vga,
    input  logic                 reset,
    input  logic [VGA_WIDTH-1:0] vdata,
    cell_ram_arbiter_if.slave    bus,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [DATA_W-1:0]    ram_wdata,
    input  logic [DATA_W-1:0]    ram_rdata
);

    typedef enum logic [1:0] {
        G_IDLE = 2'd0,
        G_WAIT = 2'd1,
        G_HOLD = 2'd2
    } g_state_t;

    localparam logic [VGA_WIDTH-1:0] VSIZE_C        = VGA_WIDTH'(VSIZE);
    localparam logic [31:0]          STARVE_LIMIT_C = 32'(STARVE_LIMIT);

    g_state_t           state_r;
    g_state_t           state_nxt_s;
    logic               in_vblank_s;
    logic               write_ok_s;
    logic               render_issue_s;
    logic               game_issue_s;
    logic               read_issue_s;
    logic [15:0]        wait_cnt_r;
    logic [15:0]        wait_cnt_nxt_s;
    logic               game_starve_r;
    logic [RAM_LAT-1:0] tag_valid_r;
    logic [RAM_LAT-1:0] tag_game_r;

    // Issue decision: render always wins; reset blocks any RAM access immediately.
    always_comb begin
        in_vblank_s    = (vdata >= VSIZE_C);
        write_ok_s     = !bus.game_we || !WRITE_IN_VBLANK || in_vblank_s;
        render_issue_s = bus.render_req && !reset;
        game_issue_s   = bus.game_req && !bus.render_req && write_ok_s && !reset;
        read_issue_s   = render_issue_s || (game_issue_s && !bus.game_we);
    end

    // RAM port and game acknowledge, driven in the same cycle as the request.
    always_comb begin
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = {ADDR_W{1'b0}};
        ram_wdata    = {DATA_W{1'b0}};
        bus.game_ack = 1'b0;
        if (render_issue_s) begin
            ram_en   = 1'b1;
            ram_addr = bus.render_addr;
        end else if (game_issue_s) begin
            ram_en       = 1'b1;
            ram_we       = bus.game_we;
            ram_addr     = bus.game_addr;
            ram_wdata    = bus.game_wdata;
            bus.game_ack = 1'b1;
        end else begin
            ram_en = 1'b0;
        end
    end

    // Game FSM next state; a pending request with render idle can only be vblank-gated.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            G_IDLE, G_WAIT, G_HOLD: begin
                if (!bus.game_req) begin
                    state_nxt_s = G_IDLE;
                end else if (game_issue_s) begin
                    state_nxt_s = G_IDLE;
                end else if (!bus.render_req) begin
                    state_nxt_s = G_HOLD;
                end else begin
                    state_nxt_s = G_WAIT;
                end
            end
            default: state_nxt_s = G_IDLE;
        endcase
    end

    // Saturating wait counter; clears on ack or when the request goes away.
    always_comb begin
        wait_cnt_nxt_s = 16'd0;
        if (bus.game_req && !game_issue_s) begin
            if (wait_cnt_r == 16'hFFFF) begin
                wait_cnt_nxt_s = wait_cnt_r;
            end else begin
                wait_cnt_nxt_s = wait_cnt_r + 16'd1;
            end
        end else begin
            wait_cnt_nxt_s = 16'd0;
        end
    end

    // FSM state, wait counter and starve flag registers.
    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            state_r       <= G_IDLE;
            wait_cnt_r    <= 16'd0;
            game_starve_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            wait_cnt_r    <= wait_cnt_nxt_s;
            game_starve_r <= ({16'd0, wait_cnt_nxt_s} >= STARVE_LIMIT_C);
        end
    end

    // Return-tag pipeline, one stage per cycle of RAM read latency.
    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            tag_valid_r <= {RAM_LAT{1'b0}};
            tag_game_r  <= {RAM_LAT{1'b0}};
        end else begin
            tag_valid_r[0] <= read_issue_s;
            tag_game_r[0]  <= game_issue_s;
            for (int i = 1; i < RAM_LAT; i++) begin
                tag_valid_r[i] <= tag_valid_r[i-1];
                tag_game_r[i]  <= tag_game_r[i-1];
            end
        end
    end

    // Return routing: valids come from the tag flops, data is steered from the RAM under them.
    always_comb begin
        bus.render_rvalid = tag_valid_r[RAM_LAT-1] && !tag_game_r[RAM_LAT-1];
        bus.game_rvalid   = tag_valid_r[RAM_LAT-1] && tag_game_r[RAM_LAT-1];
        bus.game_starve   = game_starve_r;
        bus.render_rdata  = {DATA_W{1'b0}};
        bus.game_rdata    = {DATA_W{1'b0}};
        if (bus.render_rvalid) begin
            bus.render_rdata = ram_rdata;
        end else if (bus.game_rvalid) begin
            bus.game_rdata = ram_rdata;
        end else begin
            bus.render_rdata = {DATA_W{1'b0}};
        end
    end

endmodule

// File: doc/cell_ram_arbiter.md
Name: cell_ram_arbiter

Overview:
- Shares one single-port cell-state RAM between two requesters, one access per clk_vga cycle.
- Requester 1 is the pixel renderer, which supplies gen_red/gen_green/gen_blue and use_gen to the pixel mixer. It has absolute priority and a fixed read latency.
- Requester 2 is the game logic (board updates). It uses a req/ack handshake, and its writes can be held back to vertical blanking so the displayed frame does not tear.

Parameters:
- VGA_WIDTH, 12, width of vdata.
- VSIZE, 480, first vblank line; in_vblank = (vdata >= VSIZE).
- ADDR_W, 9, cell RAM address width (board cells).
- DATA_W, 16, cell word width.
- RAM_LAT, 1, RAM read latency in cycles (1..3).
- WRITE_IN_VBLANK, 1, if 1 game writes are granted only while in_vblank; if 0 they are granted any free cycle.
- STARVE_LIMIT, 1024, waiting cycles after which game_starve asserts.

Ports:
- clk_vga  in  1  pixel clock, 25 MHz.
- reset  in  1  asynchronous, active-high reset.
- vdata  in  VGA_WIDTH  current line from the VGA timing generator.
- render_req  in  1  render read request; may be high every cycle.
- render_addr  in  ADDR_W  render read address.
- render_rvalid  out  1  render read data valid.
- render_rdata  out  DATA_W  render read data.
- game_req  in  1  game request; held with addr/we/wdata stable until game_ack.
- game_we  in  1  1 = write, 0 = read.
- game_addr  in  ADDR_W  game address.
- game_wdata  in  DATA_W  game write data.
- game_ack  out  1  one-cycle pulse; the request is issued to the RAM this cycle.
- game_rvalid  out  1  game read data valid.
- game_rdata  out  DATA_W  game read data.
- game_starve  out  1  game request has waited at least STARVE_LIMIT cycles.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, RAM_LAT cycles after a read issue.

Behaviour:
- Reset values (all asynchronous): ram_en, ram_we, game_ack, render_rvalid, game_rvalid, game_starve = 0. ram_addr, ram_wdata, render_rdata, game_rdata = 0. Tag pipeline cleared; wait counter = 0; FSM = G_IDLE.
- Issue is combinational from the requests in the same cycle; all returned data is registered.
- Render issue: render_req=1 -> ram_en=1, ram_we=0, ram_addr=render_addr. render_rvalid=1 exactly RAM_LAT cycles later, with render_rdata = ram_rdata. The render path is never stalled.
- Game FSM:
  - G_IDLE: game_req=1 -> go to G_WAIT.
  - G_WAIT: the game request is issued in the same cycle if render_req=0 and (game_we=0 or WRITE_IN_VBLANK=0 or in_vblank). On issue: ram_en=1, ram_we=game_we, ram_addr=game_addr, ram_wdata=game_wdata, game_ack=1, go to G_IDLE.
  - Requests are evaluated in the cycle game_req first rises, so the minimum ack latency is 0 cycles.
  - A write blocked only by vblank gating is in sub-state G_HOLD. G_HOLD is a reported state with identical issue rules, used for debug and coverage.
- Game read return: game_rvalid=1 RAM_LAT cycles after the ack of a read, with game_rdata = ram_rdata. Game writes produce no rvalid.
- Return routing: a RAM_LAT-deep shift register of {valid, owner} tags. Exactly one of render_rvalid/game_rvalid is high per returned read.
- Simultaneous render_req and game_req: render wins; game_ack=0; the wait counter increments.
- Wait counter: 16-bit, saturating.
  - Increments each cycle game_req=1 without game_ack.
  - Clears on game_ack or when game_req=0.
  - game_starve = (count >= STARVE_LIMIT), registered.
- A write issued on the last vblank line completes normally. Gating is evaluated per cycle, with no look-ahead.
- game_req dropped before ack (protocol violation): FSM returns to G_IDLE; no access is issued.
- Reset mid-operation: in-flight reads are discarded and no rvalid is produced after reset deassertion. The RAM contents are not touched.
- Read-after-write to the same address in consecutive cycles returns the RAM's behaviour; no forwarding.

Test Plan:
- Render only: render_req=1 for 10 cycles, addr 0..9, RAM_LAT=1 -> render_rvalid high on cycles 1..10 with data for addr 0..9. game_ack stays 0.
- Contention: render_req=1 cycles 0..4, game read addr 0x1A0 from cycle 0 -> game_ack at cycle 5, game_rvalid at cycle 6 with mem[0x1A0]. Wait count reaches 5, then clears.
- Vblank gating: game write addr 5, data 0xBEEF at vdata=100 -> no ack until vdata=480, then ack on the first render-free cycle. Subsequent render read of addr 5 returns 0xBEEF.
- WRITE_IN_VBLANK=0: same write at vdata=100 with render idle -> ack in the same cycle.
- Starvation: render_req held high, game_req high, STARVE_LIMIT=8 -> game_starve rises after 8 waiting cycles and falls the cycle after the eventual ack.
- Reset mid-read: assert reset one cycle after a game read ack with RAM_LAT=2 -> game_rvalid never asserts; all outputs return to 0 immediately.
